// File: rtl/custom_slave_axi4_burst_mem.sv
// AXI4 INCR burst slave backed by a word-addressed RAM (32-bit beats).
// Ports: S_AXI_ACLK/S_AXI_ARESET, AW/W/B write channels, AR/R read channels.
module custom_slave_axi4_burst_mem #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AW     = 10
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    input  logic [ID_WIDTH-1:0]   S_AXI_AWID,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]            S_AXI_AWLEN,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [ID_WIDTH-1:0]   S_AXI_BID,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]            S_AXI_ARLEN,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]   S_AXI_RID,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);
    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [MEM_AW-1:0] ONE = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [31:0] mem [0:DEPTH-1];

    // Address ready is held off until the first edge after reset release.
    logic live;

    wstate_t ws, ws_n;
    logic [ID_WIDTH-1:0] awid_q, awid_n;
    logic [MEM_AW-1:0] waddr, waddr_n;
    logic [7:0] wlen, wlen_n, wbeat, wbeat_n;
    logic err, err_n, wr_en;

    rstate_t rs, rs_n;
    logic [ID_WIDTH-1:0] rid_q, rid_n;
    logic [MEM_AW-1:0] raddr, raddr_n;
    logic [7:0] rlen, rlen_n, fcnt, fcnt_n;
    logic [31:0] rdata_q, rdata_n;
    logic rvalid_q, rvalid_n, rlast_q, rlast_n;

    // Address bits outside the RAM index are ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[ADDR_WIDTH-1:MEM_AW+2],
                                S_AXI_AWADDR[1:0],
                                S_AXI_ARADDR[ADDR_WIDTH-1:MEM_AW+2],
                                S_AXI_ARADDR[1:0]};

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) live <= 1'b0;
        else              live <= 1'b1;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ws     <= W_IDLE;
            awid_q <= '0;
            waddr  <= '0;
            wlen   <= '0;
            wbeat  <= '0;
            err    <= 1'b0;
        end else begin
            ws     <= ws_n;
            awid_q <= awid_n;
            waddr  <= waddr_n;
            wlen   <= wlen_n;
            wbeat  <= wbeat_n;
            err    <= err_n;
        end
    end

    always_comb begin
        ws_n          = ws;
        awid_n        = awid_q;
        waddr_n       = waddr;
        wlen_n        = wlen;
        wbeat_n       = wbeat;
        err_n         = err;
        wr_en         = 1'b0;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        unique case (ws)
            W_IDLE: begin
                S_AXI_AWREADY = live;
                if (live && S_AXI_AWVALID) begin
                    awid_n  = S_AXI_AWID;
                    waddr_n = S_AXI_AWADDR[MEM_AW+1:2];
                    wlen_n  = S_AXI_AWLEN;
                    wbeat_n = '0;
                    err_n   = 1'b0;
                    ws_n    = W_DATA;
                end
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID) begin
                    wr_en = 1'b1;
                    // Beat count, not WLAST, ends the burst; WLAST only flags errors.
                    if (S_AXI_WLAST != (wbeat == wlen)) err_n = 1'b1;
                    waddr_n = waddr + ONE;
                    wbeat_n = wbeat + 8'd1;
                    if (wbeat == wlen) ws_n = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) begin
                    err_n = 1'b0;
                    ws_n  = W_IDLE;
                end
            end
            default: ws_n = W_IDLE;
        endcase
    end

    assign S_AXI_BID   = awid_q;
    assign S_AXI_BRESP = (ws == W_RESP && err) ? 2'b10 : 2'b00;

    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (S_AXI_WSTRB[i]) mem[waddr][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rs       <= R_IDLE;
            rid_q    <= '0;
            raddr    <= '0;
            rlen     <= '0;
            fcnt     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            rs       <= rs_n;
            rid_q    <= rid_n;
            raddr    <= raddr_n;
            rlen     <= rlen_n;
            fcnt     <= fcnt_n;
            rdata_q  <= rdata_n;
            rvalid_q <= rvalid_n;
            rlast_q  <= rlast_n;
        end
    end

    // The output register refills whenever it is empty or being drained,
    // giving one beat per cycle; sampling the RAM at the clock edge means a
    // same-cycle write to that word is not yet visible.
    always_comb begin
        rs_n          = rs;
        rid_n         = rid_q;
        raddr_n       = raddr;
        rlen_n        = rlen;
        fcnt_n        = fcnt;
        rdata_n       = rdata_q;
        rvalid_n      = rvalid_q;
        rlast_n       = rlast_q;
        S_AXI_ARREADY = 1'b0;
        unique case (rs)
            R_IDLE: begin
                S_AXI_ARREADY = live;
                if (live && S_AXI_ARVALID) begin
                    rid_n   = S_AXI_ARID;
                    raddr_n = S_AXI_ARADDR[MEM_AW+1:2];
                    rlen_n  = S_AXI_ARLEN;
                    fcnt_n  = '0;
                    rs_n    = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && rlast_q) begin
                    if (S_AXI_RREADY) begin
                        rvalid_n = 1'b0;
                        rlast_n  = 1'b0;
                        rs_n     = R_IDLE;
                    end
                end else if (!rvalid_q || S_AXI_RREADY) begin
                    rvalid_n = 1'b1;
                    rdata_n  = mem[raddr];
                    rlast_n  = (fcnt == rlen);
                    raddr_n  = raddr + ONE;
                    fcnt_n   = fcnt + 8'd1;
                end
            end
            default: rs_n = R_IDLE;
        endcase
    end

    assign S_AXI_RID    = rid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = 2'b00;
    assign S_AXI_RLAST  = rlast_q;
    assign S_AXI_RVALID = rvalid_q;
endmodule

// File: tb/tb_custom_slave_axi4_burst_mem.sv
// Directed bench for custom_slave_axi4_burst_mem (16-word RAM instance).
// Each task drives one scenario and checks results inline.
module tb_custom_slave_axi4_burst_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [0:0]  awid = '0, bid, arid = '0, rid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic rlast, rvalid, rready = 1'b0;

    custom_slave_axi4_burst_mem #(
        .ID_WIDTH(1), .ADDR_WIDTH(32), .MEM_AW(4)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] wbuf [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input logic [3:0] strb, input int last_at,
                               input logic id, output logic [1:0] resp,
                               output logic bid_o, output int beats);
        int n;
        beats = 0;
        resp = 2'b11;
        bid_o = ~id;
        awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin tick(); n++; end
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at);
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin tick(); n++; end
            if (wready) beats++;
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        if (bvalid) begin resp = bresp; bid_o = bid; end
        tick();
        bready = 1'b0;
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                              input bit toggle, input logic id,
                              output logic [255:0] data, output logic [7:0] lasts,
                              output logic [1:0] resp, output int beats,
                              output int unstable, output int id_bad);
        int cyc, n;
        logic hold;
        logic [31:0] hd;
        logic hl;
        data = '0; lasts = '0; resp = '0;
        beats = 0; unstable = 0; id_bad = 0;
        hold = 1'b0; hd = '0; hl = 1'b0; cyc = 0;
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        while (beats <= int'(len) && cyc < 200) begin
            rready = toggle ? cyc[0] : 1'b1;
            if (hold && (!rvalid || rdata !== hd || rlast !== hl)) unstable++;
            if (rvalid && rready) begin
                data[beats*32 +: 32] = rdata;
                lasts[beats] = rlast;
                resp = resp | rresp;
                if (rid !== id) id_bad++;
                beats++;
            end
            hold = rvalid && !rready;
            hd = rdata; hl = rlast;
            tick();
            cyc++;
        end
        rready = 1'b0;
    endtask

    logic [255:0] seq8;
    logic [255:0] rd;
    logic [7:0]   lasts;
    logic [1:0]   resp;
    logic         b_id;
    int           beats, unstable, id_bad;

    task automatic test_reset();
        tick(); tick();
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, bid, rid, bresp,
             rresp, rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy/vld=%b%b%b%b%b rdata=%h expected all 0",
                     awready, arready, wready, bvalid, rvalid, rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (awready !== 1'b0 || arready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got aw=%b ar=%b expected 0 0", awready, arready);
        end
        tick();
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got aw=%b ar=%b expected 1 1", awready, arready);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) wbuf[i] = 32'(i + 1);
        write_burst(32'h0, 8'd7, 4'hF, 7, 1'b0, resp, b_id, beats);
        checks++;
        if (beats != 8 || resp !== 2'b00 || b_id !== 1'b0) begin
            errors++;
            $display("FAIL basic_write: got beats=%0d bresp=%b bid=%b expected 8 00 0",
                     beats, resp, b_id);
        end
        read_burst(32'h0, 8'd7, 1'b0, 1'b1, rd, lasts, resp, beats, unstable, id_bad);
        checks++;
        if (rd !== seq8) begin
            errors++;
            $display("FAIL basic_rdata: got %h expected %h", rd, seq8);
        end
        checks++;
        if (lasts !== 8'h80 || resp !== 2'b00 || id_bad != 0) begin
            errors++;
            $display("FAIL basic_rlast_rresp_rid: got last=%b resp=%b idbad=%0d expected 10000000 00 0",
                     lasts, resp, id_bad);
        end
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL basic_rvalid_drop: got %b expected 0", rvalid);
        end
    endtask

    task automatic test_stall();
        read_burst(32'h0, 8'd7, 1'b1, 1'b0, rd, lasts, resp, beats, unstable, id_bad);
        checks++;
        if (rd !== seq8 || beats != 8) begin
            errors++;
            $display("FAIL stall_rdata: got %h beats=%0d expected %h 8", rd, beats, seq8);
        end
        checks++;
        if (unstable != 0 || lasts !== 8'h80) begin
            errors++;
            $display("FAIL stall_hold: got unstable=%0d last=%b expected 0 10000000",
                     unstable, lasts);
        end
    endtask

    task automatic test_reset_mid();
        int b, n;
        araddr = 32'h0; arlen = 8'd7; arid = 1'b0; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        tick();
        arvalid = 1'b0; rready = 1'b1;
        b = 0; n = 0;
        while (b < 2 && n < 50) begin
            if (rvalid) b++;
            tick();
            n++;
        end
        checks++;
        if (b != 2 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got beats=%0d rvalid=%b expected 2 1", b, rvalid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_async: got rvalid=%b rdata=%h expected 0 0", rvalid, rdata);
        end
        rready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (arready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_arready_early: got %b expected 0", arready);
        end
        tick();
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: got arready=%b rvalid=%b expected 1 0",
                     arready, rvalid);
        end
        read_burst(32'h0, 8'd7, 1'b0, 1'b0, rd, lasts, resp, beats, unstable, id_bad);
        checks++;
        if (rd !== seq8) begin
            errors++;
            $display("FAIL midreset_reread: got %h expected %h", rd, seq8);
        end
    endtask

    task automatic test_strobe();
        wbuf[0] = 32'h11223344;
        write_burst(32'h10, 8'd0, 4'hF, 0, 1'b1, resp, b_id, beats);
        checks++;
        if (resp !== 2'b00 || b_id !== 1'b1) begin
            errors++;
            $display("FAIL strobe_bid: got bresp=%b bid=%b expected 00 1", resp, b_id);
        end
        wbuf[0] = 32'hAABBCCDD;
        write_burst(32'h10, 8'd0, 4'b0011, 0, 1'b0, resp, b_id, beats);
        read_burst(32'h10, 8'd0, 1'b0, 1'b0, rd, lasts, resp, beats, unstable, id_bad);
        checks++;
        if (rd[31:0] !== 32'h1122CCDD || lasts !== 8'h01) begin
            errors++;
            $display("FAIL strobe_merge: got %h last=%b expected 1122ccdd 00000001",
                     rd[31:0], lasts);
        end
    endtask

    task automatic test_wlast_err();
        logic [255:0] expd;
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 32'h100 + 32'(i);
            expd[i*32 +: 32] = 32'h100 + 32'(i);
        end
        write_burst(32'h20, 8'd7, 4'hF, 3, 1'b0, resp, b_id, beats);
        checks++;
        if (beats != 8 || resp !== 2'b10) begin
            errors++;
            $display("FAIL early_wlast: got beats=%0d bresp=%b expected 8 10", beats, resp);
        end
        read_burst(32'h20, 8'd7, 1'b0, 1'b0, rd, lasts, resp, beats, unstable, id_bad);
        checks++;
        if (rd !== expd) begin
            errors++;
            $display("FAIL early_wlast_data: got %h expected %h", rd, expd);
        end
        write_burst(32'h20, 8'd1, 4'hF, 1, 1'b0, resp, b_id, beats);
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("FAIL clean_after_err: got bresp=%b expected 00", resp);
        end
        write_burst(32'h20, 8'd1, 4'hF, 5, 1'b0, resp, b_id, beats);
        checks++;
        if (beats != 2 || resp !== 2'b10) begin
            errors++;
            $display("FAIL missing_wlast: got beats=%0d bresp=%b expected 2 10", beats, resp);
        end
    endtask

    task automatic test_wrap();
        wbuf[0] = 32'hAAAA000A; wbuf[1] = 32'hBBBB000B;
        wbuf[2] = 32'hCCCC000C; wbuf[3] = 32'hDDDD000D;
        write_burst(32'h38, 8'd3, 4'hF, 3, 1'b0, resp, b_id, beats);
        checks++;
        if (beats != 4 || resp !== 2'b00) begin
            errors++;
            $display("FAIL wrap_write: got beats=%0d bresp=%b expected 4 00", beats, resp);
        end
        read_burst(32'h0, 8'd1, 1'b0, 1'b0, rd, lasts, resp, beats, unstable, id_bad);
        checks++;
        if (rd[63:0] !== 64'hDDDD000D_CCCC000C || lasts !== 8'h02) begin
            errors++;
            $display("FAIL wrap_low: got %h last=%b expected dddd000dcccc000c 00000010",
                     rd[63:0], lasts);
        end
        read_burst(32'h38, 8'd1, 1'b0, 1'b0, rd, lasts, resp, beats, unstable, id_bad);
        checks++;
        if (rd[63:0] !== 64'hBBBB000B_AAAA000A) begin
            errors++;
            $display("FAIL wrap_high: got %h expected bbbb000baaaa000a", rd[63:0]);
        end
        read_burst(32'h40, 8'd0, 1'b0, 1'b0, rd, lasts, resp, beats, unstable, id_bad);
        checks++;
        if (rd[31:0] !== 32'hCCCC000C) begin
            errors++;
            $display("FAIL alias: got %h expected cccc000c", rd[31:0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) seq8[i*32 +: 32] = 32'(i + 1);
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
        test_strobe();
        test_wlast_err();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
